sbox_cfg_chain: RTL
===================

Name: sbox_cfg_chain

Overview:
- Parametrised programmable switch box for the FPGA routing fabric.
- Four sides, each with N pins. Every output pin is driven from any input pin on any side, selected by a per-pin route entry.
- Route entries load through a serial configuration shift chain into a shadow register. A commit handshake copies the shadow into the active routing state atomically.
- Pins are split into unidirectional in/out/oe triples; pad or tri-state merging happens in the tile wrapper.

Parameters:
- NTB, 5: pins per top and per bottom side.
- NLR, 4: pins per left and per right side.
- IDXW, 3: pin-index field width; must satisfy 2^IDXW >= max(NTB,NLR).
- EW, IDXW+3 (derived, not overridable): route entry width, {idx[IDXW-1:0], sel[2:0]}.
- CHAIN_LEN, 2*(NTB+NLR)*EW (derived): shift chain length; 108 at defaults.

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous reset, active-high.
- cfg_en  in  1  shift-enable; one chain bit per cycle when high.
- cfg_din  in  1  serial config bit.
- cfg_commit  in  1  single-cycle pulse; transfers shadow to active.
- cfg_ready  out  1  exactly CHAIN_LEN bits shifted since last commit/reset/restart.
- cfg_err  out  1  sticky: commit requested while not ready.
- cfg_dout  out  1  shadow bit 0 before shift (chain daisy-out).
- top_in / bottom_in  in  NTB  side input pins.
- right_in / left_in  in  NLR  side input pins.
- top_out, top_oe / bottom_out, bottom_oe  out  NTB each  routed value and drive-enable.
- right_out, right_oe / left_out, left_oe  out  NLR each  routed value and drive-enable.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Entry layout: shadow and active are CHAIN_LEN-bit vectors. Entry k occupies bits [k*EW +: EW].
- Entry order: top[0..NTB-1], right[0..NLR-1], bottom[0..NTB-1], left[0..NLR-1].
- Shift: when cfg_en and the shift is not dropped, shadow <= {cfg_din, shadow[CHAIN_LEN-1:1]}. Bit 0 of the stream is sent first. cfg_dout = shadow[0] (registered value).
- sel decode: 1 = top, 2 = right, 3 = bottom, 4 = left. Values 0 and 5..7 mean off.
- Routing (combinational from active, zero latency): out = <side>_in[idx] and oe = 1 when sel is valid and idx < width of the selected side. Otherwise out = 0 and oe = 0.
  - Same-side selection is legal because in and out are separate nets.
- FSM states: IDLE, LOAD, READY. Counter bit_cnt has width clog2(CHAIN_LEN+1).
  - IDLE: cfg_en -> LOAD, bit_cnt = 1.
  - LOAD: each cfg_en increments bit_cnt. When the increment reaches CHAIN_LEN -> READY.
  - READY: cfg_ready = 1. A further cfg_en shifts, goes to LOAD with bit_cnt = 1 (a new stream restarts) and drops cfg_ready the next cycle.
  - Commit in READY: active <= shadow on that edge; -> IDLE; bit_cnt = 0; cfg_ready = 0 the following cycle. New routing is visible on the outputs from the cycle after the commit.
  - Commit in IDLE or LOAD: active is unchanged, cfg_err <= 1, and state and bit_cnt are unchanged.
- Simultaneous cfg_en and cfg_commit: commit is evaluated first.
  - In READY, the shift is dropped (shadow not shifted) and the commit proceeds.
  - In IDLE or LOAD, the shift proceeds normally and cfg_err is set.
- cfg_en low holds all state; gaps in the stream are allowed.
- Reset values (any time, including mid-load):
  - shadow = 0, active = 0, so all oe = 0 and all out = 0.
  - state = IDLE, bit_cnt = 0, cfg_ready = 0, cfg_err = 0, cfg_dout = 0.
- cfg_err clears only on rst.
- The shadow is never observable on the routing outputs before a commit.

Test Plan:
- Reset then no config: all *_oe = 0 and *_out = 0. Toggle all inputs -> outputs stay 0.
- Load 108 bits with entry top[0] = {idx 2, sel 2} and all else 0. cfg_ready rises after the 108th shift. Before the commit, top_oe[0] = 0. After the commit, top_oe[0] = 1 and top_out[0] follows right_in[2] across toggles.
- Invalid index: left[1] = {idx 4, sel 2} (NLR = 4), committed -> left_oe[1] = 0, left_out[1] = 0. sel = 6 on bottom[3] -> bottom_oe[3] = 0.
- Commit after 50 shifts -> cfg_err = 1, active unchanged, state LOAD. Completing the remaining 58 shifts then committing applies the config; cfg_err stays 1 until rst.
- cfg_en and cfg_commit in the same READY cycle -> commit applied with the pre-edge shadow, no shift, state IDLE. Assert rst at shift 70 of a reload -> all outputs 0 and cfg_ready = 0 next cycle.
- Two configs back-to-back (A committed, then B streamed) -> routing stays A during the whole B stream and switches to B exactly one cycle after the B commit. cfg_dout replays the A stream delayed by 108 shifts.

Source files
------------

// File: rtl/sbox_cfg_chain.sv
// Programmable four-sided switch box. A serial shift chain loads route entries into a shadow register.
// A commit copies the shadow into the active routing state in one atomic step.
module sbox_cfg_chain #(
  parameter int unsigned NTB  = 5,
  parameter int unsigned NLR  = 4,
  parameter int unsigned IDXW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_en,
  input  logic           cfg_din,
  input  logic           cfg_commit,
  output logic           cfg_ready,
  output logic           cfg_err,
  output logic           cfg_dout,
  input  logic [NTB-1:0] top_in,
  input  logic [NLR-1:0] right_in,
  input  logic [NTB-1:0] bottom_in,
  input  logic [NLR-1:0] left_in,
  output logic [NTB-1:0] top_out,
  output logic [NTB-1:0] top_oe,
  output logic [NLR-1:0] right_out,
  output logic [NLR-1:0] right_oe,
  output logic [NTB-1:0] bottom_out,
  output logic [NTB-1:0] bottom_oe,
  output logic [NLR-1:0] left_out,
  output logic [NLR-1:0] left_oe
);

  localparam int unsigned EW        = IDXW + 3;
  localparam int unsigned NPIN      = 2 * (NTB + NLR);
  localparam int unsigned CHAIN_LEN = NPIN * EW;
  localparam int unsigned CNTW      = $clog2(CHAIN_LEN + 1);
  localparam int unsigned PADW      = 1 << IDXW;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_READY} state_t;

  state_t                 state_q;
  logic [CNTW-1:0]        cnt_q;
  logic [CNTW-1:0]        cnt_d;
  logic [CHAIN_LEN-1:0]   shadow_q;
  logic [CHAIN_LEN-1:0]   shadow_d;
  logic [CHAIN_LEN-1:0]   active_q;
  logic                   ready_q;
  logic                   err_q;

  assign shadow_d = {cfg_din, shadow_q[CHAIN_LEN-1:1]};
  assign cnt_d    = cnt_q + CNTW'(1);

  // Commit in READY takes priority and swallows a coincident shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
    end else if (cfg_commit && (state_q == ST_READY)) begin
      active_q <= shadow_q;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (cfg_commit) begin
        err_q <= 1'b1;
      end
      if (cfg_en) begin
        shadow_q <= shadow_d;
        if (state_q == ST_LOAD) begin
          cnt_q <= cnt_d;
          if (cnt_d == CNTW'(CHAIN_LEN)) begin
            state_q <= ST_READY;
            ready_q <= 1'b1;
          end
        end else begin
          // IDLE or READY: this bit starts a fresh stream
          cnt_q   <= CNTW'(1);
          state_q <= ST_LOAD;
          ready_q <= 1'b0;
        end
      end
    end
  end

  assign cfg_ready = ready_q;
  assign cfg_err   = err_q;
  assign cfg_dout  = shadow_q[0];

  // Side inputs padded to the full index range so any idx is a legal bit select.
  logic [PADW-1:0] top_x;
  logic [PADW-1:0] right_x;
  logic [PADW-1:0] bottom_x;
  logic [PADW-1:0] left_x;

  assign top_x    = PADW'(top_in);
  assign right_x  = PADW'(right_in);
  assign bottom_x = PADW'(bottom_in);
  assign left_x   = PADW'(left_in);

  logic [NPIN-1:0] route_val;
  logic [NPIN-1:0] route_oe;
  logic [2:0]      sel;
  logic [IDXW-1:0] idx;

  always_comb begin
    route_val = '0;
    route_oe  = '0;
    sel       = '0;
    idx       = '0;
    for (int k = 0; k < int'(NPIN); k++) begin
      sel = active_q[k*EW +: 3];
      idx = active_q[k*EW+3 +: IDXW];
      unique case (sel)
        3'd1: begin
          route_oe[k]  = (32'(idx) < NTB);
          route_val[k] = route_oe[k] & top_x[idx];
        end
        3'd2: begin
          route_oe[k]  = (32'(idx) < NLR);
          route_val[k] = route_oe[k] & right_x[idx];
        end
        3'd3: begin
          route_oe[k]  = (32'(idx) < NTB);
          route_val[k] = route_oe[k] & bottom_x[idx];
        end
        3'd4: begin
          route_oe[k]  = (32'(idx) < NLR);
          route_val[k] = route_oe[k] & left_x[idx];
        end
        default: begin
          route_oe[k]  = 1'b0;
          route_val[k] = 1'b0;
        end
      endcase
    end
  end

  // Entry order along the chain: top, right, bottom, left.
  assign top_out    = route_val[0 +: NTB];
  assign top_oe     = route_oe[0 +: NTB];
  assign right_out  = route_val[NTB +: NLR];
  assign right_oe   = route_oe[NTB +: NLR];
  assign bottom_out = route_val[NTB+NLR +: NTB];
  assign bottom_oe  = route_oe[NTB+NLR +: NTB];
  assign left_out   = route_val[2*NTB+NLR +: NLR];
  assign left_oe    = route_oe[2*NTB+NLR +: NLR];

endmodule
